// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and sign-magnitude helpers for the fc heads.
package fc_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned FC1_BATCHES = 32;
  localparam int unsigned FC1_NODES   = 64;
  localparam int unsigned FC2_NODES   = 10;
  localparam int unsigned PIPE_LAT    = 8;

  // Enable windows cover the issue phase plus the pipeline drain.
  localparam int unsigned FC1_WIN = FC1_BATCHES * FC1_NODES + PIPE_LAT;
  localparam int unsigned FC2_WIN = FC2_NODES + PIPE_LAT;
  localparam int unsigned CNT_W   = $clog2(FC1_WIN);
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFc1,
    StSnap,
    StFc2,
    StArgmax
  } fc_state_e;

  // Sign-magnitude a > b; a zero magnitude counts as positive zero.
  function automatic logic sm_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    logic                  na;
    logic                  nb;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    na = a[DATA_WIDTH-1] && (ma != '0);
    nb = b[DATA_WIDTH-1] && (mb != '0);
    if (na != nb) begin
      return nb;
    end else if (!na) begin
      return ma > mb;
    end else begin
      return ma < mb;
    end
  endfunction

endpackage

// File: rtl/sm_argmax_seq.sv
// Sequential arg-max scanner: one sign-magnitude compare per cycle while go is high.
// idx/valid are combinational on the final element so the caller can latch them on that edge.
module sm_argmax_seq
  import fc_pkg::*;
#(
  parameter int unsigned N = FC2_NODES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [N*DATA_WIDTH-1:0] vec,
  output logic [IDX_W-1:0]        idx,
  output logic                    valid
);

  logic [DATA_WIDTH-1:0] elem [N];
  logic [IDX_W-1:0]      k_q;
  logic [IDX_W-1:0]      best_idx_q;
  logic [DATA_WIDTH-1:0] best_val_q;
  logic [IDX_W-1:0]      best_idx_d;
  logic [DATA_WIDTH-1:0] best_val_d;
  logic                  last;

  for (genvar g = 0; g < N; g++) begin : g_elem
    assign elem[g] = vec[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Element 0 seeds the running best; later elements replace it only when strictly greater.
  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    last       = (k_q == IDX_W'(N - 1));
    if ((k_q == '0) || sm_gt(elem[k_q], best_val_q)) begin
      best_idx_d = k_q;
      best_val_d = elem[k_q];
    end
    idx   = best_idx_d;
    valid = go && last;
  end

  // Scan index and running best; index rewinds whenever the scan is idle or complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (go) begin
      k_q        <= last ? '0 : k_q + IDX_W'(1);
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end else begin
      k_q <= '0;
    end
  end

endmodule

// File: rtl/fc_sequencer.sv
// Sequences fc1 then fc2, snapshots ReLU'd fc1 results for fc2, then reports the arg-max class.
module fc_sequencer
  import fc_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [FC1_NODES*DATA_WIDTH-1:0]   fc1_out,
  input  logic [FC2_NODES*DATA_WIDTH-1:0]   fc2_out,
  output logic                              fc_clr,
  output logic                              fc1_en,
  output logic                              fc2_en,
  output logic [FC1_NODES*DATA_WIDTH-1:0]   fc2_data,
  output logic                              busy,
  output logic                              done,
  output logic [3:0]                        class_id
);

  // Counter loads are the window length minus one so each window ends on count 0.
  localparam logic [CNT_W-1:0] Fc1Load = CNT_W'(FC1_WIN - 1);
  localparam logic [CNT_W-1:0] Fc2Load = CNT_W'(FC2_WIN - 1);
  localparam logic [CNT_W-1:0] ArgLoad = CNT_W'(FC2_NODES - 1);

  fc_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [FC1_NODES*DATA_WIDTH-1:0]   fc2_data_q;
  logic [FC1_NODES*DATA_WIDTH-1:0]   relu_vec;
  logic                              done_q;
  logic [3:0]                        class_q;
  logic                              scan_go;
  logic [IDX_W-1:0]                  scan_idx;
  logic                              scan_valid;

  // ReLU in sign-magnitude: any set sign bit (including -0) yields +0.
  for (genvar g = 0; g < FC1_NODES; g++) begin : g_relu
    assign relu_vec[g*DATA_WIDTH +: DATA_WIDTH] =
        fc1_out[(g+1)*DATA_WIDTH-1] ? '0 : fc1_out[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state, counter reload on state entry, and per-state enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_clr  = 1'b0;
    fc1_en  = 1'b0;
    fc2_en  = 1'b0;
    scan_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          cnt_d   = '0;
        end
      end
      StClr: begin
        fc_clr  = 1'b1;
        state_d = StFc1;
        cnt_d   = Fc1Load;
      end
      StFc1: begin
        fc1_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = StSnap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSnap: begin
        state_d = StFc2;
        cnt_d   = Fc2Load;
      end
      StFc2: begin
        fc2_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = StArgmax;
          cnt_d   = ArgLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StArgmax: begin
        scan_go = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    busy = (state_q != StIdle);
  end

  // State and window counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // fc2 operand register only changes on the single SNAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc2_data_q <= '0;
    end else if (state_q == StSnap) begin
      fc2_data_q <= relu_vec;
    end
  end

  // Result latch: done pulses for one cycle, class_id holds until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      class_q <= '0;
    end else begin
      done_q <= scan_valid;
      if (scan_valid) begin
        class_q <= scan_idx;
      end
    end
  end

  sm_argmax_seq #(
    .N(FC2_NODES)
  ) u_argmax (
    .clk  (clk),
    .rst  (rst),
    .go   (scan_go),
    .vec  (fc2_out),
    .idx  (scan_idx),
    .valid(scan_valid)
  );

  assign fc2_data = fc2_data_q;
  assign done     = done_q;
  assign class_id = class_q;

endmodule
